// File: rtl/acq_phase_sequencer.sv
// Purpose: sequences the enabled acquisition phases (scale, scan, noise, pulse, state_1ms) in fixed order.
// Latency: start rises 1 cycle after an accepted go; phases are separated by a 1-cycle gap; done follows the gap after the last phase.
// Backpressure: no ready handshake; go is dropped unless idle with a non-zero mask, abort wins over everything else.
//
// Ports:
//   clk_sys, rst_n              clock and synchronous active-low reset
//   go, abort                   single-cycle host requests
//   phase_mask, tick_div,
//   st1ms_len                   configuration, captured when go is accepted
//   state_over_n                active-low phase-complete from the phase multiplexer
//   start, time_up              one-hot phase select and shared tick towards the multiplexer
//   busy, done, phase_idx,
//   timeout_err                 status towards the host register block
//
// Optional build macro: SEQ_WATCHDOG_EN adds a per-phase tick watchdog (phases 0-3)
// that sets timeout_err and returns to IDLE. Without it timeout_err is tied low.

module acq_phase_sequencer #(
    parameter int DIV_W    = 16,
    parameter int LEN_W    = 16,
    parameter int WD_TICKS = 65535
) (
    input  logic             clk_sys,
    input  logic             rst_n,
    input  logic             go,
    input  logic             abort,
    input  logic [4:0]       phase_mask,
    input  logic [DIV_W-1:0] tick_div,
    input  logic [LEN_W-1:0] st1ms_len,
    input  logic             state_over_n,
    output logic [4:0]       start,
    output logic             time_up,
    output logic             busy,
    output logic             done,
    output logic [2:0]       phase_idx,
    output logic             timeout_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_GAP,
        S_FIN
    } state_t;

    // The tick counter serves both the phase-4 length and the watchdog, so it
    // must be wide enough for whichever limit is larger.
    localparam int WD_W  = $clog2(WD_TICKS + 1);
    localparam int CNT_W = (LEN_W > WD_W) ? LEN_W : WD_W;

    state_t           state_q, state_d;
    logic [4:0]       mask_q, mask_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] presc_q, presc_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [CNT_W-1:0] tick_cnt_q, tick_cnt_d;
    logic [1:0]       blank_q, blank_d;
    logic [2:0]       idx_q, idx_d;
    logic [4:0]       start_q, start_d;
    logic             busy_q, busy_d;
    logic             time_up_q, time_up_d;
    logic             done_q, done_d;

    logic             enter;
    logic [3:0]       pick;
    logic [CNT_W:0]   ticks_after;
    logic [LEN_W-1:0] len_eff;
    logic             phase_end;

`ifdef SEQ_WATCHDOG_EN
    logic             terr_q, terr_d;
    logic             wd_hit;
`endif

    // Lowest enabled phase strictly above 'after' (or from phase 0 when
    // from_start is set). Returns {found, index}.
    function automatic logic [3:0] pick_phase(input logic [4:0] m,
                                              input logic [2:0] after,
                                              input logic       from_start);
        logic [3:0] r;
        r = 4'd0;
        for (int i = 4; i >= 0; i--) begin
            if (m[i] && (from_start || (i > int'(after)))) begin
                r = {1'b1, 3'(i)};
            end
        end
        return r;
    endfunction

    always_comb begin
        state_d    = state_q;
        mask_d     = mask_q;
        div_d      = div_q;
        len_d      = len_q;
        presc_d    = presc_q;
        tick_cnt_d = tick_cnt_q;
        blank_d    = blank_q;
        idx_d      = idx_q;
        start_d    = start_q;
        busy_d     = busy_q;
        time_up_d  = 1'b0;
        done_d     = 1'b0;
        enter      = 1'b0;
        pick       = 4'd0;
`ifdef SEQ_WATCHDOG_EN
        terr_d     = terr_q;
`endif

        // time_up_q is the tick visible this cycle; ticks_after counts it too.
        ticks_after = {1'b0, tick_cnt_q} + (CNT_W + 1)'(1);
        len_eff     = (len_q == '0) ? LEN_W'(1) : len_q;

        // Phase 4 is purely time based; phases 0-3 wait for the multiplexer,
        // ignoring the first two cycles while its registered status catches up.
        if (idx_q == 3'd4) begin
            phase_end = time_up_q && (ticks_after >= (CNT_W + 1)'(len_eff));
        end else begin
            phase_end = (blank_q == 2'd2) && !state_over_n;
        end
`ifdef SEQ_WATCHDOG_EN
        wd_hit = (idx_q != 3'd4) && time_up_q &&
                 (ticks_after >= (CNT_W + 1)'(WD_TICKS));
`endif

        case (state_q)
            S_IDLE: begin
                if (go && (phase_mask != 5'd0)) begin
                    mask_d = phase_mask;
                    div_d  = tick_div;
                    len_d  = st1ms_len;
                    pick   = pick_phase(phase_mask, 3'd7, 1'b1);
                    enter  = 1'b1;
`ifdef SEQ_WATCHDOG_EN
                    terr_d = 1'b0;
`endif
                end
            end

            S_RUN: begin
                if (presc_q == div_q) begin
                    presc_d   = '0;
                    time_up_d = 1'b1;
                end else begin
                    presc_d = presc_q + DIV_W'(1);
                end
                if (time_up_q) begin
                    tick_cnt_d = ticks_after[CNT_W-1:0];
                end
                if (blank_q != 2'd2) begin
                    blank_d = blank_q + 2'd1;
                end

                if (phase_end) begin
                    state_d   = S_GAP;
                    start_d   = 5'd0;
                    time_up_d = 1'b0;
                end
`ifdef SEQ_WATCHDOG_EN
                else if (wd_hit) begin
                    state_d   = S_IDLE;
                    start_d   = 5'd0;
                    time_up_d = 1'b0;
                    busy_d    = 1'b0;
                    idx_d     = 3'd7;
                    terr_d    = 1'b1;
                end
`endif
            end

            S_GAP: begin
                pick = pick_phase(mask_q, idx_q, 1'b0);
                if (pick[3]) begin
                    enter = 1'b1;
                end else begin
                    state_d = S_FIN;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    idx_d   = 3'd7;
                end
            end

            S_FIN: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Phase entry: prescaler, tick and blanking counters restart.
        if (enter) begin
            state_d    = S_RUN;
            idx_d      = pick[2:0];
            start_d    = 5'b00001 << pick[2:0];
            busy_d     = 1'b1;
            presc_d    = '0;
            tick_cnt_d = '0;
            blank_d    = 2'd0;
            time_up_d  = 1'b0;
        end

        // Abort overrides any phase end, gap decision or watchdog hit.
        if (abort && (state_q != S_IDLE)) begin
            state_d   = S_IDLE;
            start_d   = 5'd0;
            time_up_d = 1'b0;
            busy_d    = 1'b0;
            done_d    = 1'b0;
            idx_d     = 3'd7;
`ifdef SEQ_WATCHDOG_EN
            terr_d    = terr_q;
`endif
        end
    end

    always_ff @(posedge clk_sys) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            mask_q     <= 5'd0;
            div_q      <= '0;
            len_q      <= '0;
            presc_q    <= '0;
            tick_cnt_q <= '0;
            blank_q    <= 2'd0;
            idx_q      <= 3'd7;
            start_q    <= 5'd0;
            busy_q     <= 1'b0;
            time_up_q  <= 1'b0;
            done_q     <= 1'b0;
`ifdef SEQ_WATCHDOG_EN
            terr_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            mask_q     <= mask_d;
            div_q      <= div_d;
            len_q      <= len_d;
            presc_q    <= presc_d;
            tick_cnt_q <= tick_cnt_d;
            blank_q    <= blank_d;
            idx_q      <= idx_d;
            start_q    <= start_d;
            busy_q     <= busy_d;
            time_up_q  <= time_up_d;
            done_q     <= done_d;
`ifdef SEQ_WATCHDOG_EN
            terr_q     <= terr_d;
`endif
        end
    end

    assign start     = start_q;
    assign time_up   = time_up_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign phase_idx = idx_q;
`ifdef SEQ_WATCHDOG_EN
    assign timeout_err = terr_q;
`else
    assign timeout_err = 1'b0;
`endif

endmodule

// File: doc/acq_phase_sequencer.md
Name: acq_phase_sequencer

Overview:
- Upstream controller for the acquisition phase multiplexer.
- Walks an enabled subset of the five acquisition phases in fixed order: scale(0), scan(1), noise(2), pulse(3), state_1ms(4).
- Drives the one-hot phase select `start[4:0]` and the shared `time_up` tick. Consumes the multiplexed active-low `state_over_n` to advance between phases.
- Sits between the host command register block and the phase multiplexer.

Parameters:
- DIV_W, 16, width of the tick prescaler divisor.
- LEN_W, 16, width of the state_1ms length counter.
- WD_TICKS, 65535, watchdog limit in time_up ticks per phase (used only with SEQ_WATCHDOG_EN).

Ports:
- clk_sys  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- go  in  1  single-cycle sequence start request
- abort  in  1  single-cycle abort request
- phase_mask  in  5  phase enables, bit i = phase i
- tick_div  in  DIV_W  time_up period minus 1, in clk_sys cycles
- st1ms_len  in  LEN_W  duration of phase 4, in time_up ticks
- state_over_n  in  1  active-low phase-complete from the multiplexer
- start  out  5  one-hot phase select; all-zero when idle or in a gap
- time_up  out  1  one-cycle tick, every tick_div+1 cycles while in RUN
- busy  out  1  high from go acceptance until return to IDLE
- done  out  1  one-cycle pulse on normal completion
- phase_idx  out  3  current phase index; 7 when idle
- timeout_err  out  1  sticky watchdog flag; stays 0 without SEQ_WATCHDOG_EN

Behaviour:
- Reset: all outputs registered. start=0, time_up=0, busy=0, done=0, phase_idx=7, timeout_err=0, FSM=IDLE. All counters cleared.
- FSM states:
  - IDLE, RUN, GAP, FIN.
- Transitions:
  - IDLE: when go=1 and phase_mask!=0, latch phase_mask, tick_div and st1ms_len. Select the lowest set bit. Next cycle: RUN, start one-hot, busy=1.
  - IDLE, go with phase_mask=0: ignored; no busy, no done.
  - go while busy: ignored.
- RUN:
  - Prescaler is cleared on phase entry. The first time_up comes tick_div+1 cycles after start rises. tick_div=0 gives time_up every cycle.
  - Blanking: state_over_n is ignored for the first 2 cycles of each phase, to cover the multiplexer's 1-cycle register latency.
  - Phases 0-3 end on state_over_n sampled 0 after blanking.
  - Phase 4 ignores state_over_n. It ends on the cycle its st1ms_len-th time_up is issued. st1ms_len=0 is treated as 1.
  - On phase end: RUN -> GAP.
- GAP:
  - Exactly 1 cycle with start=0 and time_up=0, so the multiplexer returns to its default.
  - Then RUN with the next higher latched enabled phase, or FIN if none remain.
- FIN: done=1 for 1 cycle, busy=0, phase_idx=7, then IDLE.
- Abort: abort=1 in any non-IDLE state forces IDLE on the next edge.
  - start=0, time_up=0, busy=0, no done pulse.
  - Abort has priority over a simultaneous phase end.
  - Abort in IDLE has no effect.
- time_up is never asserted outside RUN.
- phase_idx always matches the set bit of start while in RUN. In GAP it holds the previous phase.
- Latched configuration is stable for the whole sequence. Input changes while busy have no effect until the next go.
- start is always one-hot or zero; never more than one bit set.

Optional Feature:
- Macro SEQ_WATCHDOG_EN.
- Defined:
  - A per-phase time_up counter clears on phase entry.
  - If it reaches WD_TICKS in phases 0-3 without state_over_n low, timeout_err is set (sticky) and the FSM aborts to IDLE (no done).
  - timeout_err is cleared only by reset or by the next accepted go.
  - Phase 4 is exempt from the watchdog.
- Undefined: no watchdog logic; timeout_err is tied to 0 and phases 0-3 wait indefinitely.

Test Plan:
- Single phase: reset; mask=5'b00001, tick_div=3, go. Expect:
  - start=00001 one cycle after go.
  - time_up pulses 4 cycles apart.
  - Drive state_over_n=0 at cycle 10: GAP (start=0) for 1 cycle, then FIN, done=1 for 1 cycle, busy=0.
- Multi-phase ordering: mask=5'b10110, st1ms_len=3, tick_div=0. Expect:
  - start sequence 00010, 00100, 10000, each separated by a 1-cycle zero gap.
  - Phase 4 lasts exactly 3 time_up ticks.
  - done after phase 4.
- Blanking: hold state_over_n=0 continuously, mask=5'b00011. Expect each phase to last exactly 3 cycles (2 blank cycles + exit), then done.
- Abort: mask=5'b01000, abort at the 5th cycle of RUN while state_over_n=0 on the same cycle. Expect:
  - start=0 and busy=0 on the next edge, with no done pulse.
  - A following go restarts cleanly.
- Ignored requests:
  - go with mask=0: busy stays 0.
  - Second go mid-sequence: no restart.
  - Changing tick_div mid-phase: time_up period unchanged.
- SEQ_WATCHDOG_EN with WD_TICKS=8, mask=5'b00001, state_over_n held 1. Expect:
  - timeout_err=1 and start=0 after the 8th time_up, with no done.
  - timeout_err clears on the next go.
